// File: rtl/pt2262_pkg.sv
// -----------------------------------------------------------------------------
// pt2262_pkg
// Shared definitions for the PT2262-compatible encoder and the PT2272 decoder:
// code-symbol and frame-state enums, waveform timing constants (in units of
// one oscillator period, alpha) and a helper that maps an address input pair
// onto a trit.
// -----------------------------------------------------------------------------
package pt2262_pkg;

  // Symbol currently being shaped onto the wire. TRIT_SYNC is never stored in
  // the frame register; it selects the sync pulse shape.
  typedef enum logic [1:0] {
    TRIT_0    = 2'd0,
    TRIT_1    = 2'd1,
    TRIT_F    = 2'd2,
    TRIT_SYNC = 2'd3
  } trit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CODE = 2'd2,
    SYNC = 2'd3
  } frame_state_t;

  // Waveform timing, in alpha.
  localparam int NARROW_A    = 4;
  localparam int WIDE_A      = 12;
  localparam int HALF_A      = 16;
  localparam int BIT_A       = 32;
  localparam int SYNC_HIGH_A = 4;
  localparam int SYNC_A      = 128;

  // The float flag wins over the value bit.
  function automatic trit_t trit_of(input logic val, input logic float_f);
    if (float_f) return TRIT_F;
    return val ? TRIT_1 : TRIT_0;
  endfunction

endpackage

// File: rtl/pt2262_bit_shaper.sv
// -----------------------------------------------------------------------------
// pt2262_bit_shaper
// Purely combinational: returns the wire level for a symbol at a given alpha
// position within that symbol.
//   trit  in  trit_t  symbol (0, 1, F, or sync)
//   pos   in  7       alpha position: 0..31 for a code bit, 0..127 for sync
//   level out 1       wire level at that position
// -----------------------------------------------------------------------------
module pt2262_bit_shaper
  import pt2262_pkg::*;
(
  input  trit_t      trit,
  input  logic [6:0] pos,
  output logic       level
);

  logic wide;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    wide  = 1'b0;
    level = 1'b0;
    if (trit == TRIT_SYNC) begin
      level = (pos < 7'(SYNC_HIGH_A));
    end else begin
      // pos[4] selects the second half-bit; F is narrow then wide.
      wide  = (trit == TRIT_1) || ((trit == TRIT_F) && pos[4]);
      level = (pos[3:0] < (wide ? 4'(WIDE_A) : 4'(NARROW_A)));
    end
  end

endmodule

// File: rtl/pt2262_encoder.sv
// -----------------------------------------------------------------------------
// pt2262_encoder
// PT2262-compatible serial encoder. On te it snapshots N_ADDR address trits and
// N_DATA data bits and sends one frame (address trits, data bits, sync) on
// cod_o; frames repeat back to back, separated by a single low cycle, while te
// is still high at the end of each frame.
//   osc_clk    in  1       oscillator clock
//   reset      in  1       asynchronous, active-high reset
//   te         in  1       transmit enable (level)
//   A_val      in  N_ADDR  address value per trit
//   A_f        in  N_ADDR  float flag per trit (1 = F, overrides A_val)
//   D          in  N_DATA  data bits
//   cod_o      out 1       registered serial code output
//   busy       out 1       high from LOAD through the end of sync
//   frame_done out 1       pulse on the last cycle of each frame
// -----------------------------------------------------------------------------
module pt2262_encoder
  import pt2262_pkg::*;
#(
  parameter int ALPHA_DIV = 1,
  parameter int N_ADDR    = 8,
  parameter int N_DATA    = 4
) (
  input  logic              osc_clk,
  input  logic              reset,
  input  logic              te,
  input  logic [N_ADDR-1:0] A_val,
  input  logic [N_ADDR-1:0] A_f,
  input  logic [N_DATA-1:0] D,
  output logic              cod_o,
  output logic              busy,
  output logic              frame_done
);

  localparam int N_BITS = N_ADDR + N_DATA;
  localparam int IW     = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int PW     = (ALPHA_DIV > 1) ? $clog2(ALPHA_DIV) : 1;

  frame_state_t          state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  // One position counter serves both phases: 0..31 inside a code bit,
  // 0..127 inside sync.
  logic [6:0]            pos_q, pos_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic [N_BITS-1:0][1:0] trits_q, trits_d;
  logic                  cod_o_q, cod_o_d;

  logic                  alpha_tick;
  trit_t                 shape_trit;
  logic                  shape_level;

  assign alpha_tick = (presc_q == PW'(ALPHA_DIV - 1));

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    pos_d      = pos_q;
    bit_idx_d  = bit_idx_q;
    trits_d    = trits_q;
    frame_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (te) state_d = LOAD;
      end

      LOAD: begin
        for (int i = 0; i < N_ADDR; i++) trits_d[i] = trit_of(A_val[i], A_f[i]);
        for (int i = 0; i < N_DATA; i++) trits_d[N_ADDR+i] = trit_of(D[i], 1'b0);
        presc_d   = '0;
        pos_d     = '0;
        bit_idx_d = '0;
        state_d   = CODE;
      end

      CODE: begin
        if (!alpha_tick) begin
          presc_d = presc_q + PW'(1);
        end else begin
          presc_d = '0;
          if (pos_q != 7'(BIT_A - 1)) begin
            pos_d = pos_q + 7'd1;
          end else begin
            pos_d = '0;
            if (bit_idx_q == IW'(N_BITS - 1)) begin
              bit_idx_d = '0;
              state_d   = SYNC;
            end else begin
              bit_idx_d = bit_idx_q + IW'(1);
            end
          end
        end
      end

      SYNC: begin
        if (!alpha_tick) begin
          presc_d = presc_q + PW'(1);
        end else begin
          presc_d = '0;
          if (pos_q != 7'(SYNC_A - 1)) begin
            pos_d = pos_q + 7'd1;
          end else begin
            // te is only looked at here, so a frame always runs to completion.
            pos_d      = '0;
            frame_done = 1'b1;
            state_d    = te ? LOAD : IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // The shaper looks at the symbol and position of the *next* cycle so that
  // cod_o can be registered and still line up with the counters. Leaving LOAD,
  // trits_d already holds the fresh snapshot.
  assign shape_trit = (state_d == SYNC) ? TRIT_SYNC : trit_t'(trits_d[bit_idx_d]);
  assign cod_o_d    = ((state_d == CODE) || (state_d == SYNC)) && shape_level;

  pt2262_bit_shaper u_shaper (
    .trit  (shape_trit),
    .pos   (pos_d),
    .level (shape_level)
  );

  always_ff @(posedge osc_clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      pos_q     <= '0;
      bit_idx_q <= '0;
      trits_q   <= '0;
      cod_o_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      pos_q     <= pos_d;
      bit_idx_q <= bit_idx_d;
      trits_q   <= trits_d;
      cod_o_q   <= cod_o_d;
    end
  end

  assign cod_o = cod_o_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_pt2262_encoder.sv
// -----------------------------------------------------------------------------
// tb_pt2262_encoder
// Self-checking bench for pt2262_encoder with default parameters (ALPHA_DIV=1,
// so one alpha is one osc_clk cycle). Expected frames are built from the
// waveform rules as a list of high/low segments and compared as whole frames.
// -----------------------------------------------------------------------------
module tb_pt2262_encoder;

  localparam int FRAME_LEN = 512;

  logic       osc_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       te      = 1'b0;
  logic [7:0] A_val   = '0;
  logic [7:0] A_f     = '0;
  logic [3:0] D       = '0;
  logic       cod_o, busy, frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int done_total = 0;

  pt2262_encoder dut (
    .osc_clk    (osc_clk),
    .reset      (reset),
    .te         (te),
    .A_val      (A_val),
    .A_f        (A_f),
    .D          (D),
    .cod_o      (cod_o),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 osc_clk = ~osc_clk;

  always @(negedge osc_clk) if (frame_done) done_total++;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference frame: each half-bit is (high, low) alpha; sync is 4 high, 124 low.
  function automatic logic [511:0] model_wave(input logic [7:0] av, input logic [7:0] af,
                                              input logic [3:0] d);
    logic q[$];
    logic [511:0] w;
    int sym, h0, h1;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) sym = af[k] ? 2 : int'(av[k]);
      else       sym = int'(d[k-8]);
      h0 = (sym == 1) ? 12 : 4;
      h1 = (sym == 0) ? 4 : 12;
      repeat (h0) q.push_back(1'b1);
      repeat (16 - h0) q.push_back(1'b0);
      repeat (h1) q.push_back(1'b1);
      repeat (16 - h1) q.push_back(1'b0);
    end
    repeat (4) q.push_back(1'b1);
    repeat (124) q.push_back(1'b0);
    w = '0;
    for (int i = 0; i < q.size(); i++) w[i] = q[i];
    return w;
  endfunction

  // High-time per frame: 0 -> 8, 1 -> 24, F -> 16, plus 4 for sync.
  function automatic int model_highs(input logic [7:0] av, input logic [7:0] af,
                                     input logic [3:0] d);
    int n = 4;
    for (int k = 0; k < 8; k++) n += af[k] ? 16 : (av[k] ? 24 : 8);
    for (int k = 0; k < 4; k++) n += d[k] ? 24 : 8;
    return n;
  endfunction

  // Called at a negedge; advances to the next negedge where busy is high
  // (the LOAD cycle) and then captures the following FRAME_LEN cycles.
  task automatic capture_frame(input string tag, input logic [7:0] av,
                               input logic [7:0] af, input logic [3:0] d);
    logic [511:0] wave;
    int busy_cnt, done_cnt, done_at, waited;
    bit started;
    wave = '0; busy_cnt = 0; done_cnt = 0; done_at = -1; waited = 0;
    @(negedge osc_clk);
    while (!busy && waited < 2000) begin
      @(negedge osc_clk);
      waited++;
    end
    started = busy;
    check({tag, "_start"}, started, 1'b1);
    if (!started) return;
    check({tag, "_load_low"}, cod_o, 1'b0);
    busy_cnt = 1;
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(negedge osc_clk);
      wave[i] = cod_o;
      if (busy) busy_cnt++;
      if (frame_done) begin
        done_cnt++;
        done_at = i;
      end
    end
    check({tag, "_wave"}, wave, model_wave(av, af, d));
    check({tag, "_highs"}, $countones(wave), model_highs(av, af, d));
    check({tag, "_busy_cycles"}, busy_cnt, FRAME_LEN + 1);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_at"}, done_at, FRAME_LEN - 1);
  endtask

  task automatic pulse_te();
    @(negedge osc_clk);
    te = 1'b1;
    @(posedge osc_clk);
    #1 te = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge osc_clk);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_cod"}, cod_o, 1'b0);
    repeat (20) @(negedge osc_clk);
    check({tag, "_stays_idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] av, af;
    logic [3:0] d;
    int dn0, waited;

    // Reset values while reset is held.
    #12;
    check("rst_cod", cod_o, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    @(negedge osc_clk);
    reset = 1'b0;
    repeat (3) @(negedge osc_clk);
    check("idle_busy", busy, 1'b0);

    // All-zero frame from a one-cycle te pulse.
    A_val = 8'h00; A_f = 8'h00; D = 4'h0;
    pulse_te();
    capture_frame("zeros", 8'h00, 8'h00, 4'h0);
    expect_idle("zeros");

    // All-one frame.
    A_val = 8'hFF; A_f = 8'h00; D = 4'hF;
    pulse_te();
    capture_frame("ones", 8'hFF, 8'h00, 4'hF);
    expect_idle("ones");

    // Float address, A_val ignored.
    A_val = 8'h5A; A_f = 8'hFF; D = 4'h0;
    pulse_te();
    capture_frame("float", 8'h5A, 8'hFF, 4'h0);
    expect_idle("float");

    // Random frames with inputs scrambled mid-frame.
    for (int n = 0; n < 4; n++) begin
      av = 8'($urandom); af = 8'($urandom); d = 4'($urandom);
      A_val = av; A_f = af; D = d;
      pulse_te();
      fork
        capture_frame($sformatf("rand%0d", n), av, af, d);
        begin
          repeat (100 + $urandom_range(0, 300)) @(negedge osc_clk);
          A_val = 8'($urandom); A_f = 8'($urandom); D = 4'($urandom);
        end
      join
      expect_idle($sformatf("rand%0d", n));
    end

    // te held for three frames, D changes during frame 1, te drops in frame 3.
    av = 8'($urandom); af = 8'($urandom);
    A_val = av; A_f = af; D = 4'h5;
    dn0 = done_total;
    @(negedge osc_clk);
    te = 1'b1;
    fork
      begin
        capture_frame("rep1", av, af, 4'h5);
        capture_frame("rep2", av, af, 4'hA);
        capture_frame("rep3", av, af, 4'hA);
      end
      begin
        repeat (200) @(negedge osc_clk);
        D = 4'hA;
        repeat (1000) @(negedge osc_clk);
        te = 1'b0;
      end
    join
    expect_idle("rep");
    check("rep_done_pulses", done_total - dn0, 3);

    // Reset mid-frame, then restart with te held high.
    A_val = 8'($urandom); A_f = 8'($urandom); D = 4'($urandom);
    pulse_te();
    repeat (200) @(negedge osc_clk);
    te = 1'b1;
    dn0 = done_total;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_cod", cod_o, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", frame_done, 1'b0);
    @(negedge osc_clk);
    @(negedge osc_clk);
    reset = 1'b0;
    @(posedge osc_clk);
    #1;
    check("restart_load_busy", busy, 1'b1);
    check("restart_load_cod", cod_o, 1'b0);
    @(posedge osc_clk);
    #1;
    check("restart_first_high", cod_o, 1'b1);
    check("mid_rst_no_done", done_total - dn0, 0);
    te = 1'b0;
    waited = 0;
    while (busy && waited < 2000) begin
      @(negedge osc_clk);
      waited++;
    end
    check("restart_ends", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pt2262_encoder.md
Name: pt2262_encoder

Overview:
- Serial PT2262-compatible encoder. It is the transmit-side counterpart of the team's pt2272 decoder.
- Latches an 8-trit address (0/1/F) and a 4-bit data word, then drives one-wire code frames on cod_o.
- Frames repeat while te is high.
- Runs in the osc_clk domain (12 kHz oscillator clock derived from the 3 MHz system clock). One oscillator period α equals ALPHA_DIV osc_clk cycles.

Parameters:
- ALPHA_DIV, 1, osc_clk cycles per α (1..16).
- N_ADDR, 8, number of address trits.
- N_DATA, 4, number of data bits.

Ports:
- osc_clk  in  1  block clock.
- reset  in  1  asynchronous, active-high reset.
- te  in  1  transmit enable, level, sampled on osc_clk rising edge.
- A_val  in  N_ADDR  address value per trit (used when A_f[i]=0).
- A_f  in  N_ADDR  float flag per trit; 1 = trit F, overrides A_val[i].
- D  in  N_DATA  data bits (binary only).
- cod_o  out  1  encoded serial output.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock osc_clk.
- Reset values: cod_o=0, busy=0, frame_done=0, FSM=IDLE, all counters 0.
- Half-bit shapes (16α each):
  - narrow = 4α high, 12α low.
  - wide = 12α high, 4α low.
- Code bits (32α each):
  - 0 = narrow, narrow.
  - 1 = wide, wide.
  - F = narrow, wide.
- Sync = 4α high, 124α low (128α).
- Frame order: trit A[0] … A[N_ADDR-1], then D[0] … D[N_DATA-1], then sync.
- Frame length for defaults: (12·32+128)α = 512α.
- FSM states:
  - IDLE: cod_o=0, busy=0. If te=1 → LOAD.
  - LOAD: one cycle. Snapshot A_val/A_f/D into internal trit register. busy=1, cod_o=0. → CODE.
  - CODE: α-prescaler, 5-bit position counter (0..31) and bit index (0..N_ADDR+N_DATA-1). cod_o is driven from the current trit and position. At position 31 of the last bit → SYNC.
  - SYNC: 7-bit position counter (0..127). cod_o=1 for positions 0..3, else 0. On the last cycle of position 127, frame_done=1 for one cycle, then:
    - te=1 → LOAD (one low cycle gap, then the next frame).
    - te=0 → IDLE.
- Latency: te rises → LOAD on the next edge → first cod_o high on the following edge (2 osc_clk cycles).
- cod_o is a registered output: no glitches, and its transitions align with α boundaries.
- Boundary conditions:
  - te falls mid-frame: the current frame, including sync, completes; te is only re-checked at frame end.
  - A_val/A_f/D change mid-frame: no effect on the current frame; new values apply at the next LOAD.
  - A_f[i]=1 with any A_val[i]: the trit is F.
  - reset mid-frame: immediately cod_o=0, busy=0, IDLE; no frame_done.
  - Prescaler wraps at ALPHA_DIV-1; all counters wrap only at their defined terminal values.
  - te glitch shorter than one cycle while in IDLE: ignored if not sampled; if sampled, one full frame is sent.

Decomposition:
- pt2262_pkg holds the shared definitions:
  - typedef enum logic[1:0] trit_t {TRIT_0, TRIT_1, TRIT_F, TRIT_SYNC}.
  - Constants: NARROW_A=4, WIDE_A=12, HALF_A=16, BIT_A=32, SYNC_HIGH_A=4, SYNC_A=128.
  - Frame state enum {IDLE, LOAD, CODE, SYNC}.
- The decoder and encoder share this package.
- One sub-module: pt2262_bit_shaper. Inputs: trit_t, position (0..127). Output: combinational level. Instantiated once.

Test Plan:
- A_val=8'h00, A_f=0, D=4'h0, te pulsed for 1 cycle → exactly one frame.
  - Bit 0 shows 4H/12L/4H/12L; sync shows 4H/124L.
  - cod_o high count = 100, frame length 512 cycles, busy high 513 cycles, one frame_done.
- A_val=8'hFF, A_f=0, D=4'hF → every bit shows 12H/4L/12H/4L; high count = 292.
- A_f=8'hFF, D=4'h0 → address bits show 4H/12L/12H/4L; high count = 164.
- te held high for 3 frames with D changing mid-frame 1 (4'h5→4'hA) → frame 1 carries 4'h5, frames 2–3 carry 4'hA; 1-cycle low gap between frames; 3 frame_done pulses.
- te dropped at cycle 100 of a frame → the frame completes through sync, then IDLE with cod_o=0 and busy=0.
- reset asserted at cycle 200 of a frame → same cycle cod_o=0, busy=0, no frame_done. With te=1 after release, a new frame starts 2 cycles later.
